// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
//   lsu_state_t : bus-transaction FSM states
//   F3_*        : funct3 access size/sign encodings
package lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic for the LSU.
//   funct3_i/addr_lo_i/store_data_i : current access -> be_o, wdata_o, misaligned_o
//   ld_funct3_i/ld_addr_lo_i/rdata_i : access latched at issue -> load_data_o
// Undefined funct3 encodings behave as a word access.
module load_store_align
    import lsu_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [2:0]        ld_funct3_i,
    input  logic [1:0]        ld_addr_lo_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [BE_W-1:0]   be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              misaligned_o,
    output logic [DATA_W-1:0] load_data_o
);

    logic [DATA_W-1:0] lane;

    // Store side: byte enables, lane replication, alignment check.
    always_comb begin
        be_o         = 4'hF;
        wdata_o      = store_data_i;
        misaligned_o = 1'b0;
        case (funct3_i)
            F3_LB, F3_LBU: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            F3_LH, F3_LHU: begin
                be_o         = 4'b0011 << addr_lo_i;
                wdata_o      = {2{store_data_i[15:0]}};
                misaligned_o = addr_lo_i[0];
            end
            default: misaligned_o = |addr_lo_i;
        endcase
    end

    // Shift the addressed lane down to bit 0 before extension.
    assign lane = rdata_i >> {ld_addr_lo_i, 3'b000};

    // Load side: sign/zero extension of the selected lane.
    always_comb begin
        case (ld_funct3_i)
            F3_LB:   load_data_o = {{24{lane[7]}}, lane[7:0]};
            F3_LBU:  load_data_o = {24'd0, lane[7:0]};
            F3_LH:   load_data_o = {{16{lane[15]}}, lane[15:0]};
            F3_LHU:  load_data_o = {16'd0, lane[15:0]};
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM loads/stores into req/gnt/rvalid
// bus transactions, stalls the pipeline while one is outstanding, and
// returns extended load data to MEM/WB.
//   inputs : memRead_mem, memWrite_mem, alu_result_mem, rs2_mem, funct3_mem,
//            dmem_gnt, dmem_rvalid, dmem_rdata
//   outputs: stall_mem, misaligned_mem (combinational in IDLE),
//            load_data_mem, load_valid_mem, dmem_req/we/addr/be/wdata (registered)
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memRead_mem,
    input  logic              memWrite_mem,
    input  logic [ADDR_W-1:0] alu_result_mem,
    input  logic [DATA_W-1:0] rs2_mem,
    input  logic [2:0]        funct3_mem,
    output logic              stall_mem,
    output logic [DATA_W-1:0] load_data_mem,
    output logic              load_valid_mem,
    output logic              misaligned_mem,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [BE_W-1:0]   dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        alo_q, alo_d;
    logic [DATA_W-1:0] ldata_q, ldata_d;

    logic [BE_W-1:0]   be_c;
    logic [DATA_W-1:0] wdata_c;
    logic              mis_c;
    logic [DATA_W-1:0] ldata_c;

    load_store_align u_align (
        .funct3_i     (funct3_mem),
        .addr_lo_i    (alu_result_mem[1:0]),
        .store_data_i (rs2_mem),
        .ld_funct3_i  (f3_q),
        .ld_addr_lo_i (alo_q),
        .rdata_i      (dmem_rdata),
        .be_o         (be_c),
        .wdata_o      (wdata_c),
        .misaligned_o (mis_c),
        .load_data_o  (ldata_c)
    );

    // Next-state, issue/capture and combinational stall/misaligned.
    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        addr_d         = addr_q;
        be_d           = be_q;
        wdata_d        = wdata_q;
        f3_d           = f3_q;
        alo_d          = alo_q;
        ldata_d        = ldata_q;
        stall_mem      = 1'b0;
        misaligned_mem = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (memRead_mem || memWrite_mem) begin
                    if (mis_c) begin
                        misaligned_mem = 1'b1;
                    end else begin
                        // Store wins when both flags are set.
                        stall_mem = 1'b1;
                        we_d      = memWrite_mem;
                        addr_d    = {alu_result_mem[ADDR_W-1:2], 2'b00};
                        be_d      = be_c;
                        wdata_d   = wdata_c;
                        f3_d      = funct3_mem;
                        alo_d     = alu_result_mem[1:0];
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                stall_mem = 1'b1;
                if (dmem_gnt) begin
                    if (we_q) begin
                        state_d = DONE;
                    end else if (dmem_rvalid) begin
                        ldata_d = ldata_c;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                stall_mem = 1'b1;
                if (dmem_rvalid) begin
                    ldata_d = ldata_c;
                    state_d = DONE;
                end
            end
            // EX/MEM advances on this edge; never re-evaluate the old access here.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and transaction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= 3'd0;
            alo_q   <= 2'd0;
            ldata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            alo_q   <= alo_d;
            ldata_q <= ldata_d;
        end
    end

    assign dmem_req       = (state_q == REQ);
    assign load_valid_mem = (state_q == DONE) && !we_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_be        = be_q;
    assign dmem_wdata     = wdata_q;
    assign load_data_mem  = ldata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: a driver issues directed and random
// accesses and queues the expected bus request / load result / misaligned
// event; a monitor pops and compares whenever the DUT presents one.
module tb_mem_stage_lsu;
    import lsu_pkg::*;

    localparam int K_REQ = 0;
    localparam int K_LD  = 1;
    localparam int K_MIS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memRead_mem, memWrite_mem;
    logic [31:0] alu_result_mem, rs2_mem;
    logic [2:0]  funct3_mem;
    logic        stall_mem, load_valid_mem, misaligned_mem;
    logic [31:0] load_data_mem;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    typedef struct {
        int          kind;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          len;
        logic [31:0] data;
    } ev_t;

    ev_t         sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_lv     = 0;
    int          gnt_dly  = 0;
    int          rv_dly   = 0;
    logic [31:0] cur_rdata = 32'd0;
    bit          stray    = 1'b0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.ADDR_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .memRead_mem    (memRead_mem),
        .memWrite_mem   (memWrite_mem),
        .alu_result_mem (alu_result_mem),
        .rs2_mem        (rs2_mem),
        .funct3_mem     (funct3_mem),
        .stall_mem      (stall_mem),
        .load_data_mem  (load_data_mem),
        .load_valid_mem (load_valid_mem),
        .misaligned_mem (misaligned_mem),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_gnt       (dmem_gnt),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Reference model: access size in bytes from funct3.
    function automatic int acc_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input int a);
        int sz = acc_size(f3);
        if (sz == 4) return 4'hF;
        return 4'(((1 << sz) - 1) << a);
    endfunction

    function automatic bit ref_mis(input logic [2:0] f3, input int a);
        return (a % acc_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        int sz = acc_size(f3);
        if (sz == 1) return 32'(rs2[7:0]) * 32'h0101_0101;
        if (sz == 2) return 32'(rs2[15:0]) * 32'h0001_0001;
        return rs2;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a, input logic [31:0] rd);
        int     sz = acc_size(f3);
        longint v;
        if (sz == 4) return rd;
        v = longint'(rd >> (8 * a));
        v = v % (longint'(1) << (8 * sz));
        if (f3[2] == 1'b0 && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    // Bus responder: grants after gnt_dly idle request cycles, read data rv_dly cycles after grant.
    initial begin
        int rs;
        int cnt;
        rs = 0;
        cnt = 0;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b0;
            if (!rst_n) begin
                rs = 0;
            end else begin
                if (stray) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata = 32'hA5A5_A5A5;
                end
                if (rs == 0 && dmem_req) begin
                    rs = 1;
                    cnt = gnt_dly;
                end
                if (rs == 1) begin
                    if (cnt == 0) begin
                        dmem_gnt = 1'b1;
                        if (dmem_we) begin
                            rs = 0;
                        end else if (rv_dly == 0) begin
                            dmem_rvalid = 1'b1;
                            dmem_rdata = cur_rdata;
                            rs = 0;
                        end else begin
                            cnt = rv_dly;
                            rs = 2;
                        end
                    end else begin
                        cnt--;
                    end
                end else if (rs == 2) begin
                    cnt--;
                    if (cnt == 0) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata = cur_rdata;
                        rs = 0;
                    end
                end
            end
        end
    end

    function automatic bit pop_expect(input int kind, input string name, output ev_t e);
        n_checks++;
        if (sb_q.size() == 0 || sb_q[0].kind != kind) begin
            n_fail++;
            $display("FAIL %s: DUT presented event kind %0d, scoreboard front is %0d (size %0d)",
                     name, kind, (sb_q.size() == 0) ? -1 : sb_q[0].kind, sb_q.size());
            return 1'b0;
        end
        e = sb_q.pop_front();
        return 1'b1;
    endfunction

    // Monitor: samples mid-cycle, compares DUT events against the scoreboard.
    initial begin
        ev_t         e;
        ev_t         cur;
        bit          act;
        int          len;
        logic [31:0] last_ld;
        act = 1'b0;
        len = 0;
        last_ld = 32'd0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                act = 1'b0;
                sb_q.delete();
                last_ld = 32'd0;
                continue;
            end
            if (dmem_req) begin
                if (!act) begin
                    if (pop_expect(K_REQ, "unexpected_req", e)) begin
                        chk("req_we", 32'(dmem_we), 32'(e.we));
                        chk("req_addr", dmem_addr, e.addr);
                        chk("req_be", 32'(dmem_be), 32'(e.be));
                        if (e.we) chk("req_wdata", dmem_wdata, e.wdata);
                        cur = e;
                        act = 1'b1;
                        len = 1;
                    end
                end else begin
                    len++;
                    chk("req_stable_addr", dmem_addr, cur.addr);
                    chk("req_stable_be", 32'(dmem_be), 32'(cur.be));
                end
            end else if (act) begin
                chk("req_len", 32'(len), 32'(cur.len));
                act = 1'b0;
            end
            if (load_valid_mem) begin
                n_lv++;
                if (pop_expect(K_LD, "unexpected_load_valid", e)) begin
                    chk("load_data", load_data_mem, e.data);
                    last_ld = e.data;
                end
            end else begin
                chk("load_hold", load_data_mem, last_ld);
            end
            if (misaligned_mem) begin
                if (pop_expect(K_MIS, "unexpected_misaligned", e)) begin
                    chk("mis_no_stall", 32'(stall_mem), 32'd0);
                end
            end
        end
    end

    // One EX/MEM access, held until the DUT releases the stall.
    task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [31:0] rdata, input int gd, input int rvd);
        ev_t e;
        int  exp_stall;
        int  cnt;
        int  a;
        exp_stall = 0;
        cnt = 0;
        a = int'(addr[1:0]);
        gnt_dly = gd;
        rv_dly = rvd;
        cur_rdata = rdata;
        e = '{kind: K_REQ, we: wr, addr: addr & ~32'h3, be: ref_be(f3, a),
              wdata: ref_wdata(f3, rs2), len: gd + 1, data: 32'd0};
        if (rd || wr) begin
            if (ref_mis(f3, a)) begin
                e.kind = K_MIS;
                sb_q.push_back(e);
            end else begin
                sb_q.push_back(e);
                exp_stall = gd + 2;
                if (!wr) begin
                    e.kind = K_LD;
                    e.data = ref_load(f3, a, rdata);
                    sb_q.push_back(e);
                    exp_stall += rvd;
                end
            end
        end
        memRead_mem = rd;
        memWrite_mem = wr;
        funct3_mem = f3;
        alu_result_mem = addr;
        rs2_mem = rs2;
        #1;
        while (stall_mem) begin
            cnt++;
            if (cnt > 100) begin
                $display("FAIL stall_timeout: stall_mem still high after %0d cycles, required release", cnt);
                n_fail++;
                break;
            end
            @(negedge clk);
            #1;
        end
        chk("stall_cycles", 32'(cnt), 32'(exp_stall));
        @(negedge clk);
        memRead_mem = 1'b0;
        memWrite_mem = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lv_before;
        ev_t e;
        rst_n = 1'b0;
        memRead_mem = 1'b0;
        memWrite_mem = 1'b0;
        alu_result_mem = 32'd0;
        rs2_mem = 32'd0;
        funct3_mem = 3'd0;
        #3;
        chk("reset_outputs", 32'(|{stall_mem, load_data_mem, load_valid_mem, misaligned_mem,
                                   dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        access(1'b0, 1'b1, F3_LW,  32'h0000_0100, 32'hDEAD_BEEF, 32'd0, 1, 0);
        access(1'b1, 1'b0, F3_LB,  32'h0000_0103, 32'd0, 32'h80FF_FF00, 0, 0);
        access(1'b1, 1'b0, F3_LBU, 32'h0000_0103, 32'd0, 32'h80FF_FF00, 0, 0);
        access(1'b1, 1'b0, F3_LH,  32'h0000_0102, 32'd0, 32'h7FFF_0000, 2, 2);
        access(1'b0, 1'b1, F3_LH,  32'h0000_0101, 32'h0000_1234, 32'd0, 0, 0);
        access(1'b0, 1'b1, F3_LB,  32'h0000_0202, 32'h1234_5678, 32'd0, 0, 0);
        access(1'b1, 1'b1, F3_LW,  32'h0000_0300, 32'hCAFE_F00D, 32'h1111_1111, 1, 0);
        access(1'b1, 1'b0, 3'b011, 32'h0000_040C, 32'd0, 32'h8765_4321, 0, 1);
        access(1'b1, 1'b0, F3_LW,  32'h0000_0402, 32'd0, 32'h0, 0, 0);
        access(1'b1, 1'b0, F3_LHU, 32'h0000_0502, 32'd0, 32'h9ABC_0000, 0, 3);

        for (int i = 0; i < 80; i++) begin
            logic [2:0] f3;
            bit         rd;
            bit         wr;
            f3 = 3'($urandom_range(0, 7));
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            access(rd, wr, f3, $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Reset while the load is sitting in REQ.
        gnt_dly = 8;
        rv_dly = 0;
        e = '{kind: K_REQ, we: 1'b0, addr: 32'h0000_0300, be: 4'hF, wdata: 32'd0, len: 9, data: 32'd0};
        sb_q.push_back(e);
        memRead_mem = 1'b1;
        funct3_mem = F3_LW;
        alu_result_mem = 32'h0000_0300;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre_reset_req", 32'(dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        memRead_mem = 1'b0;
        #1;
        chk("rst_drops_req", 32'(dmem_req), 32'd0);
        chk("rst_all_zero", 32'(|{stall_mem, load_data_mem, load_valid_mem, misaligned_mem,
                                  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lv_before = n_lv;
        #1;
        stray = 1'b1;
        @(negedge clk);
        #1;
        stray = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #3;
        chk("stray_rvalid_ignored", 32'(n_lv), 32'(lv_before));
        chk("stray_no_stall", 32'(stall_mem), 32'd0);
        @(negedge clk);

        access(1'b1, 1'b0, F3_LH,  32'h0000_0600, 32'd0, 32'h0000_8001, 0, 0);
        access(1'b0, 1'b1, F3_LB,  32'h0000_0601, 32'h0000_00AB, 32'd0, 1, 0);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
